grid_display_fetch: RTL

- Upstream feeder for the VGA pixel driver. It converts the driver's next_x/next_y into a cell address in the double-banked grid memory and returns that cell's 5-bit grid_info {obstacle,a,b,c,d}, aligned to the driver's next_x.
- It also arbitrates the single grid-memory port. Display owns the port during active video; the simulation engine gets a bounded window starting at enter_v_front. Banks swap only when the simulation completes inside its window.

---
 rtl/hpp_pkg.sv | 26 ++
 rtl/grid_addr_calc.sv | 26 ++
 rtl/grid_display_fetch.sv | 108 ++++++++++
 3 files changed

// File: rtl/hpp_pkg.sv
// Shared grid geometry, grid_info bit layout and port-arbiter state encoding for the
// pixel pipeline and the simulation engine.
package hpp_pkg;

   localparam int unsigned CELL_LOG2 = 2;
   localparam int unsigned GRID_W    = 160;
   localparam int unsigned GRID_H    = 120;
   localparam int unsigned ADDR_W    = 15;
   localparam int unsigned PIX_W     = 10;
   localparam int unsigned X_MAX     = (GRID_W << CELL_LOG2) - 1;

   // grid_info = {obstacle, a, b, c, d}
   localparam int unsigned OBST = 4;
   localparam int unsigned A    = 3;
   localparam int unsigned B    = 2;
   localparam int unsigned C    = 1;
   localparam int unsigned D    = 0;
   localparam int unsigned GI_W = OBST + 1;

   typedef enum logic [1:0] {
      StDisplay = 2'd0,
      StSim     = 2'd1,
      StHold    = 2'd2
   } arb_state_e;

endpackage

// File: rtl/grid_addr_calc.sv
// Pixel coordinate to grid-cell address: lookahead on x with clamp to the last column,
// shift down to cell units, row * 160 done as (row << 7) + (row << 5).
module grid_addr_calc
   import hpp_pkg::*;
#(
   parameter int unsigned PREFETCH = 2
) (
   input  logic [PIX_W-1:0]  x,
   input  logic [PIX_W-1:0]  y,
   output logic [ADDR_W-1:0] addr
);

   logic [PIX_W:0]    px_sum;
   logic [PIX_W-1:0]  px;
   logic [ADDR_W-1:0] row;
   logic [ADDR_W-1:0] col;

   always_comb begin
      px_sum = {1'b0, x} + (PIX_W + 1)'(PREFETCH);
      px     = (px_sum > (PIX_W + 1)'(X_MAX)) ? PIX_W'(X_MAX) : px_sum[PIX_W-1:0];
      col    = ADDR_W'(px >> CELL_LOG2);
      row    = ADDR_W'(y >> CELL_LOG2);
      addr   = (row << 7) + (row << 5) + col;
   end

endmodule

// File: rtl/grid_display_fetch.sv
// Display-side grid fetch and single-port arbiter: display reads the bank on screen,
// the simulation engine gets a bounded window after enter_v_front, banks swap on sim_done.
module grid_display_fetch
   import hpp_pkg::*;
#(
   parameter int unsigned PREFETCH   = 2,
   parameter int unsigned SIM_WINDOW = 35000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [PIX_W-1:0]  next_x,
   input  logic [PIX_W-1:0]  next_y,
   input  logic              enter_v_front,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_bank,
   input  logic [GI_W-1:0]   mem_rdata,
   output logic [GI_W-1:0]   grid_info,
   output logic              sim_grant,
   input  logic [ADDR_W-1:0] sim_addr,
   input  logic              sim_done,
   output logic              frame_tick,
   output logic              underrun,
   input  logic              clear_underrun
);

   localparam int unsigned CNT_W = $clog2(SIM_WINDOW + 1);

   arb_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              rd_valid_q;
   logic [ADDR_W-1:0] disp_addr;

   grid_addr_calc #(
      .PREFETCH (PREFETCH)
   ) u_addr_calc (
      .x    (next_x),
      .y    (next_y),
      .addr (disp_addr)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StDisplay;
         cnt_q      <= '0;
         rd_valid_q <= 1'b0;
         mem_addr   <= '0;
         mem_bank   <= 1'b0;
         grid_info  <= '0;
         sim_grant  <= 1'b0;
         frame_tick <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         frame_tick <= 1'b0;
         // rd_valid_q marks that mem_addr was last loaded from the display path, so the
         // first read after a simulation window is not shown.
         rd_valid_q <= (state_q == StDisplay);
         grid_info  <= (state_q == StDisplay && rd_valid_q) ? mem_rdata : '0;
         if (clear_underrun) begin
            underrun <= 1'b0;
         end

         case (state_q)
            StDisplay: begin
               mem_addr <= disp_addr;
               if (enter_v_front) begin
                  state_q   <= StSim;
                  sim_grant <= 1'b1;
                  cnt_q     <= CNT_W'(SIM_WINDOW - 1);
               end
            end
            StSim: begin
               mem_addr <= sim_addr;
               if (sim_done) begin
                  sim_grant  <= 1'b0;
                  mem_bank   <= ~mem_bank;
                  frame_tick <= 1'b1;
                  // Done on the last window cycle skips HOLD altogether.
                  if (cnt_q == '0) begin
                     state_q <= StDisplay;
                  end else begin
                     state_q <= StHold;
                     cnt_q   <= cnt_q - 1'b1;
                  end
               end else if (cnt_q == '0) begin
                  state_q   <= StDisplay;
                  sim_grant <= 1'b0;
                  underrun  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StHold: begin
               mem_addr <= disp_addr;
               if (cnt_q == '0) begin
                  state_q <= StDisplay;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q   <= StDisplay;
               sim_grant <= 1'b0;
            end
         endcase
      end
   end

endmodule
